pcie_bas_wr_responder: RTL and testbench

Avalon-MM burst-write responder for the PCIe BAS write interface. It accepts burst writes from an FPGA-to-CPU DMA initiator, stores the data flits in a local byte-enabled memory, captures done-pointer writes, and applies programmable backpressure. It models the host-memory end of the BAS path in RTL_sim. A readback port and counters let the bench or a checker compare the received data against what was sent.

---
 rtl/pcie_bas_wr_responder_pkg.sv | 18 +
 rtl/pcie_bas_wr_responder_if.sv | 24 ++
 rtl/pcie_bas_wr_responder_bram.sv | 47 ++++
 rtl/pcie_bas_wr_responder.sv | 188 ++++++++++++++++++
 tb/tb_pcie_bas_wr_responder.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pcie_bas_wr_responder_pkg.sv
// Shared types and constants for the PCIe BAS burst-write responder.
package pcie_bas_wr_responder_pkg;

  localparam int FLIT_WIDTH = 512;
  localparam int BE_WIDTH   = 64;
  localparam int MAX_BURST  = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } bas_rsp_state_t;

  // A burstcount is usable only when it is non-zero and no larger than the limit.
  function automatic logic burst_legal(input logic [3:0] bc, input int max_bc);
    return (bc != 4'd0) && (int'(bc) <= max_bc);
  endfunction

endpackage

// File: rtl/pcie_bas_wr_responder_if.sv
// Avalon-MM burst-write channel between the DMA initiator and the responder.
interface pcie_bas_wr_responder_if;
  import pcie_bas_wr_responder_pkg::*;

  logic                  pcie_bas_waitrequest;
  logic [63:0]           pcie_bas_address;
  logic [BE_WIDTH-1:0]   pcie_bas_byteenable;
  logic                  pcie_bas_write;
  logic [FLIT_WIDTH-1:0] pcie_bas_writedata;
  logic [3:0]            pcie_bas_burstcount;

  modport master (
    input  pcie_bas_waitrequest,
    output pcie_bas_address, pcie_bas_byteenable, pcie_bas_write,
    output pcie_bas_writedata, pcie_bas_burstcount
  );

  modport slave (
    output pcie_bas_waitrequest,
    input  pcie_bas_address, pcie_bas_byteenable, pcie_bas_write,
    input  pcie_bas_writedata, pcie_bas_burstcount
  );

endinterface

// File: rtl/pcie_bas_wr_responder_bram.sv
// Simple dual-port RAM with byte-enabled writes and a registered read that
// returns the pre-write contents when both ports hit the same word.
module bram_be_simple2port #(
  parameter int DWIDTH  = 512,
  parameter int BEWIDTH = 64,
  parameter int AWIDTH  = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [AWIDTH-1:0]  waddr,
  input  logic [BEWIDTH-1:0] be,
  input  logic [DWIDTH-1:0]  wdata,
  input  logic               re,
  input  logic [AWIDTH-1:0]  raddr,
  output logic [DWIDTH-1:0]  rdata
);

  localparam int DEPTH  = 1 << AWIDTH;
  localparam int BYTE_W = DWIDTH / BEWIDTH;

  logic [DWIDTH-1:0] mem_r [DEPTH];
  logic [DWIDTH-1:0] rdata_r;

  // Byte-masked write port; the array keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < BEWIDTH; b++) begin
        if (be[b]) begin
          mem_r[waddr][b*BYTE_W +: BYTE_W] <= wdata[b*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  // Registered read port that holds its value while re is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_r <= {DWIDTH{1'b0}};
    end else if (re) begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/pcie_bas_wr_responder.sv
// Host-memory end of the BAS write path: stores burst flits, captures
// done-pointer writes, throttles the initiator and keeps traffic counters.
module pcie_bas_wr_responder #(
  parameter int          AWIDTH    = 9,
  parameter logic [63:0] BASE_ADDR = 64'h0,
  parameter int          MAX_BURST = pcie_bas_wr_responder_pkg::MAX_BURST
) (
  input  logic                                          clk,
  input  logic                                          rst,
  pcie_bas_wr_responder_if.slave                        bas,
  input  logic [63:0]                                   done_addr,
  input  logic [7:0]                                    stall_period,
  input  logic                                          rd_en,
  input  logic [AWIDTH-1:0]                             rd_addr,
  output logic [pcie_bas_wr_responder_pkg::FLIT_WIDTH-1:0] rd_data,
  output logic [31:0]                                   last_ptr,
  output logic                                          last_ptr_valid,
  output logic [31:0]                                   flit_cnt,
  output logic [31:0]                                   burst_cnt,
  output logic [31:0]                                   err_cnt
);

  import pcie_bas_wr_responder_pkg::*;

  localparam logic [AWIDTH-1:0] IDX_ONE = {{(AWIDTH-1){1'b0}}, 1'b1};

  bas_rsp_state_t    state_r, state_nxt_s;
  logic [AWIDTH-1:0] idx_r, idx_nxt_s, mem_idx_s, start_idx_s;
  logic [3:0]        rem_r, rem_nxt_s;
  logic              drop_r, drop_nxt_s;
  logic              accept_s, in_range_s, mem_we_s;
  logic              flit_inc_s, burst_inc_s, err_inc_s, ptr_upd_s;
  logic [63:0]       offset_s;
  logic [7:0]        sc_r, sc_nxt_s, sp_prev_r;
  logic              wait_r;
  logic [31:0]       flit_cnt_r, burst_cnt_r, err_cnt_r, last_ptr_r;
  logic              last_ptr_valid_r;

  assign accept_s    = bas.pcie_bas_write && !wait_r;
  assign offset_s    = bas.pcie_bas_address - BASE_ADDR;
  // Offset bits above the window must all be zero; this also rejects wrap-around.
  assign in_range_s  = (bas.pcie_bas_address >= BASE_ADDR) &&
                       ((offset_s >> (AWIDTH + 6)) == 64'd0);
  assign start_idx_s = offset_s[AWIDTH+5:6];

  // Next-state and per-beat actions of the burst tracker.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    rem_nxt_s   = rem_r;
    drop_nxt_s  = drop_r;
    mem_we_s    = 1'b0;
    mem_idx_s   = idx_r;
    flit_inc_s  = 1'b0;
    burst_inc_s = 1'b0;
    err_inc_s   = 1'b0;
    ptr_upd_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (!accept_s) begin
          state_nxt_s = IDLE;
        end else if (!burst_legal(bas.pcie_bas_burstcount, MAX_BURST)) begin
          err_inc_s = 1'b1;
        end else if ((bas.pcie_bas_address == done_addr) && (bas.pcie_bas_burstcount == 4'd1)) begin
          ptr_upd_s   = 1'b1;
          burst_inc_s = 1'b1;
        end else begin
          idx_nxt_s  = start_idx_s;
          mem_idx_s  = start_idx_s;
          drop_nxt_s = !in_range_s;
          mem_we_s   = in_range_s;
          flit_inc_s = in_range_s;
          err_inc_s  = !in_range_s;
          rem_nxt_s  = bas.pcie_bas_burstcount - 4'd1;
          if (bas.pcie_bas_burstcount == 4'd1) begin
            burst_inc_s = 1'b1;
          end else begin
            state_nxt_s = BURST;
          end
        end
      end
      BURST: begin
        if (accept_s) begin
          idx_nxt_s  = idx_r + IDX_ONE;
          mem_idx_s  = idx_r + IDX_ONE;
          mem_we_s   = !drop_r;
          flit_inc_s = !drop_r;
          err_inc_s  = drop_r;
          rem_nxt_s  = rem_r - 4'd1;
          if (rem_r == 4'd1) begin
            burst_inc_s = 1'b1;
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = BURST;
          end
        end else begin
          state_nxt_s = BURST;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Burst tracker state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      idx_r   <= {AWIDTH{1'b0}};
      rem_r   <= 4'd0;
      drop_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      idx_r   <= idx_nxt_s;
      rem_r   <= rem_nxt_s;
      drop_r  <= drop_nxt_s;
    end
  end

  // Traffic counters and done-pointer capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flit_cnt_r       <= 32'd0;
      burst_cnt_r      <= 32'd0;
      err_cnt_r        <= 32'd0;
      last_ptr_r       <= 32'd0;
      last_ptr_valid_r <= 1'b0;
    end else begin
      flit_cnt_r       <= flit_cnt_r  + {31'd0, flit_inc_s};
      burst_cnt_r      <= burst_cnt_r + {31'd0, burst_inc_s};
      err_cnt_r        <= err_cnt_r   + {31'd0, err_inc_s};
      last_ptr_valid_r <= ptr_upd_s;
      if (ptr_upd_s) begin
        last_ptr_r <= bas.pcie_bas_writedata[31:0];
      end
    end
  end

  // Stall phase counter: restarts whenever the programmed period changes.
  always_comb begin
    sc_nxt_s = sc_r + 8'd1;
    if (stall_period != sp_prev_r) begin
      sc_nxt_s = 8'd0;
    end else if ((stall_period == 8'd0) || (sc_r == stall_period - 8'd1)) begin
      sc_nxt_s = 8'd0;
    end else begin
      sc_nxt_s = sc_r + 8'd1;
    end
  end

  // Registered waitrequest, held high throughout reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sc_r      <= 8'd0;
      sp_prev_r <= 8'd0;
      wait_r    <= 1'b1;
    end else begin
      sc_r      <= sc_nxt_s;
      sp_prev_r <= stall_period;
      wait_r    <= (stall_period != 8'd0) && (sc_nxt_s == stall_period - 8'd1);
    end
  end

  bram_be_simple2port #(
    .DWIDTH  (FLIT_WIDTH),
    .BEWIDTH (BE_WIDTH),
    .AWIDTH  (AWIDTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we_s),
    .waddr (mem_idx_s),
    .be    (bas.pcie_bas_byteenable),
    .wdata (bas.pcie_bas_writedata),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  assign bas.pcie_bas_waitrequest = wait_r;
  assign last_ptr       = last_ptr_r;
  assign last_ptr_valid = last_ptr_valid_r;
  assign flit_cnt       = flit_cnt_r;
  assign burst_cnt      = burst_cnt_r;
  assign err_cnt        = err_cnt_r;

endmodule

// File: tb/tb_pcie_bas_wr_responder.sv
// Directed-random bench for pcie_bas_wr_responder against a flat memory/counter model.
module tb_pcie_bas_wr_responder;

  localparam int          AW    = 9;
  localparam int          DEPTH = 1 << AW;
  localparam logic [63:0] BASE  = 64'h0;
  localparam int          MAXB  = 8;
  localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [63:0]   done_addr;
  logic [7:0]    stall_period;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [511:0]  rd_data;
  logic [31:0]   last_ptr, flit_cnt, burst_cnt, err_cnt;
  logic          last_ptr_valid;

  always #5 clk = ~clk;

  pcie_bas_wr_responder_if bas_if ();

  pcie_bas_wr_responder #(.AWIDTH(AW), .BASE_ADDR(BASE), .MAX_BURST(MAXB)) dut (
    .clk            (clk),
    .rst            (rst),
    .bas            (bas_if),
    .done_addr      (done_addr),
    .stall_period   (stall_period),
    .rd_en          (rd_en),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .last_ptr       (last_ptr),
    .last_ptr_valid (last_ptr_valid),
    .flit_cnt       (flit_cnt),
    .burst_cnt      (burst_cnt),
    .err_cnt        (err_cnt)
  );

  int           n_assert = 0;
  int           n_fail   = 0;
  int           stall_seen = 0;
  int           lpv_seen = 0;
  logic [511:0] ref_mem [DEPTH];
  logic [31:0]  ref_flit, ref_burst, ref_err, ref_ptr;

  always @(negedge clk) if (last_ptr_valid === 1'b1) lpv_seen++;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] rand_flit();
    logic [511:0] f;
    for (int i = 0; i < 16; i++) f[i*32 +: 32] = $urandom();
    return f;
  endfunction

  function automatic logic [511:0] merge(input logic [511:0] o, input logic [511:0] n, input logic [63:0] be);
    logic [511:0] r;
    r = o;
    for (int b = 0; b < 64; b++) if (be[b]) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction

  // Present one beat and hold it until the responder takes it.
  task automatic do_beat(input logic [63:0] a, input logic [3:0] bc, input logic [63:0] be, input logic [511:0] d);
    int   guard;
    logic acc;
    guard = 0;
    acc   = 1'b0;
    @(negedge clk);
    bas_if.pcie_bas_write      = 1'b1;
    bas_if.pcie_bas_address    = a;
    bas_if.pcie_bas_burstcount = bc;
    bas_if.pcie_bas_byteenable = be;
    bas_if.pcie_bas_writedata  = d;
    while (!acc && guard < 64) begin
      acc = (bas_if.pcie_bas_waitrequest === 1'b0);
      @(posedge clk);
      if (!acc) begin
        guard++;
        stall_seen++;
        @(negedge clk);
      end
    end
    if (!acc) begin
      n_assert++;
      n_fail++;
      $error("FAIL beat_timeout: observed no acceptance expected acceptance within 64 cycles");
    end
  endtask

  // Send n beats of a burst and update the model from the protocol rules.
  task automatic send_burst(input logic [63:0] addr, input int bc, input logic [63:0] be, input int n);
    logic [511:0] d;
    logic [63:0]  off;
    int           start, k;
    bit           legal, isdone, inr;
    legal  = (bc >= 1) && (bc <= MAXB);
    isdone = legal && (addr == done_addr) && (bc == 1);
    inr    = (addr >= BASE) && ((addr - BASE) < 64'(DEPTH * 64));
    off    = addr - BASE;
    start  = int'((off / 64) % DEPTH);
    for (int i = 0; i < n; i++) begin
      d = rand_flit();
      if (i == 0) do_beat(addr, 4'(bc), be, d);
      else do_beat({$urandom(), $urandom()}, 4'($urandom_range(0, 15)), be, d);
      if (!legal) ref_err++;
      else if (isdone) begin
        ref_ptr = d[31:0];
        ref_burst++;
      end else if (inr) begin
        k = (start + i) % DEPTH;
        ref_mem[k] = merge(ref_mem[k], d, be);
        ref_flit++;
      end else ref_err++;
    end
    if (legal && !isdone && n == bc) ref_burst++;
    @(negedge clk);
    bas_if.pcie_bas_write = 1'b0;
  endtask

  task automatic read_check(input int idx, input string tag);
    @(negedge clk);
    rd_en   = 1'b1;
    rd_addr = AW'(idx);
    @(negedge clk);
    rd_en   = 1'b0;
    rd_addr = AW'(idx + 1);
    chk(tag, rd_data, ref_mem[idx]);
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_flit"}, flit_cnt, ref_flit);
    chk({tag, "_burst"}, burst_cnt, ref_burst);
    chk({tag, "_err"}, err_cnt, ref_err);
    chk({tag, "_ptr"}, last_ptr, ref_ptr);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wait"}, bas_if.pcie_bas_waitrequest, 1'b1);
    chk({tag, "_rd"}, rd_data, 512'd0);
    chk({tag, "_lpv"}, last_ptr_valid, 1'b0);
    ref_flit = 32'd0; ref_burst = 32'd0; ref_err = 32'd0; ref_ptr = 32'd0;
    chk_counters(tag);
  endtask

  initial begin
    logic [511:0] d;
    logic [511:0] hold;
    int           lpv0, st;
    bas_if.pcie_bas_write      = 1'b0;
    bas_if.pcie_bas_address    = 64'd0;
    bas_if.pcie_bas_byteenable = 64'd0;
    bas_if.pcie_bas_writedata  = 512'd0;
    bas_if.pcie_bas_burstcount = 4'd0;
    done_addr    = 64'h0000_0001_0000_0000;
    stall_period = 8'd0;
    rd_en        = 1'b0;
    rd_addr      = '0;
    ref_flit = 32'd0; ref_burst = 32'd0; ref_err = 32'd0; ref_ptr = 32'd0;

    // Power-on reset state and waitrequest release.
    repeat (3) @(negedge clk);
    chk_reset_outputs("por");
    rst = 1'b0;
    @(negedge clk);
    chk("por_wait_release", bas_if.pcie_bas_waitrequest, 1'b0);

    // Fill the whole memory so every flit has a known value.
    for (int b = 0; b < DEPTH / 8; b++) send_burst(64'(b * 8 * 64), 8, ONES, 8);
    chk_counters("preload");

    // Reset keeps memory but clears all outputs.
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset_outputs("rst1");
    @(negedge clk);
    rst = 1'b0;

    // Single 8-flit burst at flit 1, readback latency and hold.
    send_burst(64'h40, 8, ONES, 8);
    chk("t1_flit_cnt", flit_cnt, 32'd8);
    chk("t1_burst_cnt", burst_cnt, 32'd1);
    chk("t1_err_cnt", err_cnt, 32'd0);
    for (int i = 1; i <= 8; i++) read_check(i, "t1_flit");
    hold = rd_data;
    @(negedge clk);
    chk("t1_rd_hold", rd_data, hold);

    // Backpressure duty: one stall in every three cycles.
    stall_period = 8'd3;
    repeat (6) @(negedge clk);
    st = 0;
    for (int i = 0; i < 30; i++) begin
      if (bas_if.pcie_bas_waitrequest === 1'b1) st++;
      @(negedge clk);
    end
    chk("stall_duty", 512'(st), 512'd10);

    // 20 flits as 8/8/4 bursts under stalls.
    stall_seen = 0;
    send_burst(64'h1000, 8, ONES, 8);
    send_burst(64'h1200, 8, ONES, 8);
    send_burst(64'h1400, 4, ONES, 4);
    chk("multi_stalled", 512'(stall_seen > 0), 512'd1);
    chk_counters("multi");
    for (int i = 64; i < 84; i++) read_check(i, "multi_flit");
    stall_period = 8'd0;

    // Done-pointer write: pointer captured, one-cycle valid pulse, no memory write.
    lpv0 = lpv_seen;
    d = rand_flit();
    d[31:0] = 32'd7;
    do_beat(done_addr, 4'd1, 64'hF, d);
    @(negedge clk);
    bas_if.pcie_bas_write = 1'b0;
    ref_ptr = 32'd7;
    ref_burst++;
    repeat (4) @(negedge clk);
    chk("done_pulse_cycles", 512'(lpv_seen - lpv0), 512'd1);
    chk_counters("done");

    // Illegal burstcounts, then a normal single beat proves the FSM stayed idle.
    send_burst(64'h80, 0, ONES, 1);
    chk("bc0_err", err_cnt, 32'd1);
    send_burst(64'h80, 1, ONES, 1);
    chk_counters("after_bc0");
    read_check(2, "after_bc0_flit");
    send_burst(64'h80, 9, ONES, 1);
    send_burst(64'h80, 15, ONES, 1);
    chk_counters("bc_over");

    // Out-of-range bursts drop every beat.
    send_burst(BASE + 64'(DEPTH * 64), 4, ONES, 4);
    send_burst(done_addr, 2, ONES, 2);
    chk_counters("oor");
    send_burst(BASE + 64'((DEPTH - 1) * 64 + 63), 1, ONES, 1);
    chk_counters("last_flit_low_bits");

    // Wrap-around inside a burst with a partial byteenable.
    send_burst(BASE + 64'((DEPTH - 1) * 64), 3, 64'h0000_0000_0000_FFFF, 3);
    chk_counters("wrap");
    read_check(DEPTH - 1, "wrap_top");
    read_check(0, "wrap_0");
    read_check(1, "wrap_1");
    for (int i = 0; i < DEPTH; i++) read_check(i, "mem_all");

    // Reset in the middle of an 8-beat burst.
    send_burst(64'h2000, 8, ONES, 2);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset_outputs("rst_mid");
    @(negedge clk);
    chk("rst_mid_wait_hold", bas_if.pcie_bas_waitrequest, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_wait_release", bas_if.pcie_bas_waitrequest, 1'b0);
    send_burst(64'h3000, 1, ONES, 1);
    chk("rst_mid_burst_cnt", burst_cnt, 32'd1);
    chk_counters("rst_mid");
    for (int i = 128; i < 131; i++) read_check(i, "rst_mid_flit");
    read_check(192, "rst_mid_fresh");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
